div_op_sequencer: RTL and testbench

Operand front-end that sits directly upstream of the restoring divider (Rest_div) and also collects its results. It buffers X/Y operand pairs from a valid/ready producer in a small FIFO, and issues each pair to the divider with a one-cycle start pulse. It waits for the divider's valid, then presents quotient/remainder on a valid/ready output port. Divide-by-zero is handled locally; a watchdog covers a hung divider.

---
 rtl/div_op_sequencer_if.sv | 30 +++
 rtl/div_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_div_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_op_sequencer_if.sv
// Link between the operand sequencer and the restoring divider.
// The master drives start and operands; the slave returns the result and valid.
interface div_op_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_valid;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    modport master (
        output div_start,
        output div_x,
        output div_y,
        input  div_valid,
        input  div_quot,
        input  div_rem
    );

    modport slave (
        input  div_start,
        input  div_x,
        input  div_y,
        output div_valid,
        output div_quot,
        output div_rem
    );
endinterface

// File: rtl/div_op_sequencer.sv
// Operand FIFO and issue/collect sequencer for the restoring divider.
// Divide-by-zero is answered locally; a watchdog ends a hung divide with an error result.
module div_op_sequencer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    div_op_sequencer_if.master       div,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_quot,
    output logic [WIDTH-1:0]         out_rem,
    output logic                     out_dbz,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_x_q [DEPTH];
    logic [WIDTH-1:0] mem_y_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] div_x_q, div_x_d, div_y_q, div_y_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d, err_q, err_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             div_valid_q;
    logic             push, pop, done_edge;
    logic [WIDTH-1:0] head_x, head_y;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign head_x    = mem_x_q[rd_ptr_q];
    assign head_y    = mem_y_q[rd_ptr_q];
    // A level that was already high when WAIT began must not count as completion.
    assign done_edge = div.div_valid && !div_valid_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        div_x_d = div_x_q;
        div_y_d = div_y_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_y == '0) begin
                        quot_d  = '1;
                        rem_d   = head_x;
                        dbz_d   = 1'b1;
                        err_d   = 1'b0;
                        state_d = StHold;
                    end else begin
                        div_x_d = head_x;
                        div_y_d = head_y;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done_edge) begin
                    quot_d  = div.div_quot;
                    rem_d   = div.div_rem;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (wd_q == WW'(TIMEOUT - 2)) begin
                    // Next count would be TIMEOUT-1: give up, HOLD lands TIMEOUT cycles after ISSUE.
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x_q[wr_ptr_q] <= in_x;
            mem_y_q[wr_ptr_q] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            div_x_q     <= '0;
            div_y_q     <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
            div_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_x_q     <= div_x_d;
            div_y_q     <= div_y_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            div_valid_q <= div.div_valid;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign div.div_start = (state_q == StIssue);
    assign div.div_x     = div_x_q;
    assign div.div_y     = div_y_q;
    assign out_valid     = (state_q == StHold);
    assign out_quot      = quot_q;
    assign out_rem       = rem_q;
    assign out_dbz       = dbz_q;
    assign out_err       = err_q;
    assign fifo_count    = count_q;
endmodule

// File: tb/tb_div_op_sequencer.sv
// Directed bench for div_op_sequencer with a behavioural divider on the slave side.
module tb_div_op_sequencer;
    localparam int unsigned WIDTH   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        logic             err;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_x, in_y;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_quot, out_rem;
    logic             out_dbz, out_err;
    logic [$clog2(DEPTH):0] fifo_count;

    div_op_sequencer_if #(.WIDTH(WIDTH)) dif ();

    div_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .div        (dif),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_quot   (out_quot),
        .out_rem    (out_rem),
        .out_dbz    (out_dbz),
        .out_err    (out_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Divider model: drops valid on start, raises it lat cycles later and keeps it high.
    logic             stuck = 1'b0;
    int               lat = 5;
    logic             mv = 1'b0;
    logic [WIDTH-1:0] mq = '0, mr = '0, mx = '0, my = '0;
    int               mcnt = 0;
    logic             mbusy = 1'b0;

    assign dif.div_valid = stuck ? 1'b1 : mv;
    assign dif.div_quot  = mq;
    assign dif.div_rem   = mr;

    always @(posedge clk) begin
        if (dif.div_start) begin
            mx    <= dif.div_x;
            my    <= dif.div_y;
            mv    <= 1'b0;
            mcnt  <= lat;
            mbusy <= 1'b1;
        end else if (mbusy) begin
            if (mcnt <= 1) begin
                mv    <= 1'b1;
                mq    <= (my == '0) ? '1 : mx / my;
                mr    <= (my == '0) ? mx : mx % my;
                mbusy <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    // Monitor: counts starts, overlap, records handshaked results and timing.
    int   cyc = 0;
    int   n_start = 0, n_overlap = 0, start_cyc = 0, hold_cyc = 0;
    logic ov_prev = 1'b0;
    res_t results[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (dif.div_start) begin
                n_start   = n_start + 1;
                start_cyc = cyc;
                if (out_valid) n_overlap = n_overlap + 1;
            end
            if (out_valid && !ov_prev) hold_cyc = cyc;
            if (out_valid && out_ready)
                results.push_back(res_t'({out_quot, out_rem, out_dbz, out_err}));
        end
        ov_prev = out_valid;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int k;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        k        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k >= 300) begin
                check("push_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k;
        k = 0;
        while (results.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("result_arrival", 32'(results.size() >= n), 1);
    endtask

    task automatic expect_res(input string tag, input int q, input int r, input int dbz,
                              input int err);
        res_t got;
        if (results.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            got = results.pop_front();
            check({tag, "_quot"}, 32'(got.q), q);
            check({tag, "_rem"}, 32'(got.r), r);
            check({tag, "_dbz"}, 32'(got.dbz), dbz);
            check({tag, "_err"}, 32'(got.err), err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

    initial begin
        int s0, o0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_start", 32'(dif.div_start), 0);
        check("rst_div_x", 32'(dif.div_x), 0);
        check("rst_div_y", 32'(dif.div_y), 0);
        check("rst_quot", 32'(out_quot), 0);
        check("rst_rem", 32'(out_rem), 0);
        check("rst_flags", 32'({out_dbz, out_err}), 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Single divide.
        sync();
        s0 = n_start;
        push(4'd15, 4'd8);
        wait_results(1, 100);
        expect_res("op15_8", 1, 7, 0, 0);
        check("op15_8_starts", 32'(n_start - s0), 1);

        // Back-to-back, one op in flight at a time.
        sync();
        s0 = n_start;
        o0 = n_overlap;
        push(4'd10, 4'd5);
        push(4'd8, 4'd4);
        push(4'd1, 4'd1);
        wait_results(3, 200);
        expect_res("op10_5", 2, 0, 0, 0);
        expect_res("op8_4", 2, 0, 0, 0);
        expect_res("op1_1", 1, 0, 0, 0);
        check("b2b_starts", 32'(n_start - s0), 3);
        check("b2b_overlap", 32'(n_overlap - o0), 0);

        // Divide-by-zero handled locally, then a normal op.
        sync();
        s0 = n_start;
        push(4'd9, 4'd0);
        push(4'd9, 4'd3);
        wait_results(2, 200);
        expect_res("dbz9", 15, 9, 1, 0);
        expect_res("op9_3", 3, 0, 0, 0);
        check("dbz_starts", 32'(n_start - s0), 1);

        // Backpressure fills the FIFO.
        sync();
        out_ready = 1'b0;
        push(4'd7, 4'd2);
        push(4'd6, 4'd3);
        push(4'd13, 4'd4);
        push(4'd11, 4'd5);
        push(4'd14, 4'd7);
        @(negedge clk);
        check("full_count", 32'(fifo_count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        fork
            push(4'd15, 4'd1);
            begin
                repeat (10) @(negedge clk);
                check("held_count", 32'(fifo_count), 4);
                check("held_no_result", 32'(results.size()), 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_results(6, 400);
        expect_res("bp7_2", 3, 1, 0, 0);
        expect_res("bp6_3", 2, 0, 0, 0);
        expect_res("bp13_4", 3, 1, 0, 0);
        expect_res("bp11_5", 2, 1, 0, 0);
        expect_res("bp14_7", 2, 0, 0, 0);
        expect_res("bp15_1", 15, 0, 0, 0);

        // Divider valid stuck high: watchdog completion.
        sync();
        stuck = 1'b1;
        push(4'd12, 4'd3);
        wait_results(1, 200);
        expect_res("timeout", 0, 0, 0, 1);
        check("timeout_latency", 32'(hold_cyc - start_cyc), TIMEOUT);
        stuck = 1'b0;

        // Reset while waiting with two entries queued.
        sync();
        lat = 20;
        push(4'd4, 4'd2);
        push(4'd6, 4'd2);
        push(4'd8, 4'd2);
        @(negedge clk);
        check("pre_rst_count", 32'(fifo_count), 2);
        check("pre_rst_out_valid", 32'(out_valid), 0);
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("abort_count", 32'(fifo_count), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        s0 = n_start;
        repeat (40) @(negedge clk);
        check("abort_no_result", 32'(results.size()), 0);
        check("abort_no_start", 32'(n_start - s0), 0);
        check("abort_idle_valid", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
